// File: rtl/cpu_mem_io_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_io_responder
//   Target-side responder for the CPU byte-wide memory bus. It holds a byte
//   RAM, an RX byte FIFO (UART -> CPU), a TX byte FIFO (CPU -> UART), a free
//   running 32-bit cycle counter with a read snapshot, and a sticky
//   program-stop flag. Reads return data one cycle after the request; writes
//   complete at the request's clock edge.
//
//   Address map (mem_a[17:0]; upper bits ignored):
//     mem_a[17:16] != 2'b11  RAM, index mem_a[16:0] (2'b10 aliases RAM)
//     0x30000                R: pop RX byte (0x00 if empty)  W: push TX byte (0x00 ignored)
//     0x30004..0x30007       R: cycle counter bytes, little-endian
//     0x30004                W: set program_done, push one 0x00 into TX
//
//   Ports:
//     clk_in, rst_in_n          clock, asynchronous active-low reset
//     mem_a/mem_dout/mem_wr     CPU request (every cycle is a request)
//     mem_din                   registered read data
//     io_buffer_full            TX FIFO near-full back-pressure
//     tx_data/tx_valid/tx_ready TX FIFO head to UART
//     rx_data/rx_valid/rx_ready UART receiver into RX FIFO
//     program_done              sticky stop flag
//
//   Optional build macro MEM_ACCESS_STATS_EN adds saturating RAM access
//   counters on stat_rd_cnt / stat_wr_cnt.
// ---------------------------------------------------------------------------

// Circular byte FIFO with a separate occupancy count. A push into a full
// FIFO is accepted only when a pop retires an entry in the same cycle.
module cpu_mem_io_byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic [DEPTH_LOG2:0]   count
);
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  pop_ok, push_ok;

    assign pop_ok  = pop && (count_q != '0);
    assign push_ok = push && ((count_q != FULL) || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers/count define what is valid.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

module cpu_mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_done
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt
`endif
);
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
    // Two-entry margin so a CPU store already in flight still fits.
    localparam logic [TX_DEPTH_LOG2:0] TX_HI_WM =
        (TX_DEPTH_LOG2+1)'((1 << TX_DEPTH_LOG2) - 2);

    // ---------------- address decode ----------------
    logic                  io_sel, io_data_sel, io_cnt_sel, io_done_sel;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic                  unused_addr_bits;

    assign io_sel      = (mem_a[17:16] == 2'b11);
    assign io_data_sel = io_sel && (mem_a[15:0] == 16'h0000);
    assign io_cnt_sel  = io_sel && (mem_a[15:2] == 14'h0001);
    assign io_done_sel = io_sel && (mem_a[15:0] == 16'h0004);
    assign ram_idx     = mem_a[RAM_ADDR_W-1:0];
    assign unused_addr_bits = ^mem_a[31:18];

    // ---------------- state ----------------
    logic [7:0]  ram [1 << RAM_ADDR_W];
    logic [7:0]  mem_din_q, mem_din_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] snapshot_q, snapshot_d;
    logic        done_q, done_d;

    logic                   ram_we;
    logic                   tx_push, rx_pop, rx_push;
    logic [7:0]             tx_push_data, tx_head, rx_head;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [RX_DEPTH_LOG2:0] rx_count;

    always_comb begin
        mem_din_d    = mem_din_q;   // write cycles leave the read data alone
        snapshot_d   = snapshot_q;
        done_d       = done_q;
        cycle_d      = cycle_q + 32'd1;
        ram_we       = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = mem_dout;
        rx_pop       = 1'b0;

        if (mem_wr) begin
            if (!io_sel) begin
                ram_we = 1'b1;
            end else if (io_data_sel) begin
                tx_push = (mem_dout != 8'h00);
            end else if (io_done_sel) begin
                done_d = 1'b1;
                // Only the first stop write emits the 0x00 marker.
                if (!done_q) begin
                    tx_push      = 1'b1;
                    tx_push_data = 8'h00;
                end
            end
        end else begin
            if (!io_sel) begin
                mem_din_d = ram[ram_idx];
            end else if (io_data_sel) begin
                rx_pop    = 1'b1;
                mem_din_d = (rx_count != '0) ? rx_head : 8'h00;
            end else if (io_cnt_sel) begin
                // Byte 0 captures the whole counter so bytes 1-3 of the same
                // word read stay coherent while the counter keeps running.
                case (mem_a[1:0])
                    2'd0: begin
                        snapshot_d = cycle_q;
                        mem_din_d  = cycle_q[7:0];
                    end
                    2'd1:    mem_din_d = snapshot_q[15:8];
                    2'd2:    mem_din_d = snapshot_q[23:16];
                    default: mem_din_d = snapshot_q[31:24];
                endcase
            end else begin
                mem_din_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            mem_din_q  <= 8'h00;
            cycle_q    <= 32'd0;
            snapshot_q <= 32'd0;
            done_q     <= 1'b0;
        end else begin
            mem_din_q  <= mem_din_d;
            cycle_q    <= cycle_d;
            snapshot_q <= snapshot_d;
            done_q     <= done_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_idx] <= mem_dout;
    end

    // ---------------- FIFOs ----------------
    assign rx_ready = (rx_count != RX_FULL);
    assign rx_push  = rx_valid && rx_ready;

    cpu_mem_io_byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_valid && tx_ready),
        .head      (tx_head),
        .count     (tx_count)
    );

    cpu_mem_io_byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk_in    (clk_in),
        .rst_in_n  (rst_in_n),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count)
    );

    assign tx_valid       = (tx_count != '0);
    assign tx_data        = tx_head;
    assign io_buffer_full = (tx_count >= TX_HI_WM);
    assign mem_din        = mem_din_q;
    assign program_done   = done_q;

`ifdef MEM_ACCESS_STATS_EN
    // ---------------- RAM access statistics ----------------
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (!io_sel && !mem_wr && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
        if (!io_sel &&  mem_wr && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
`endif
endmodule

// File: tb/tb_cpu_mem_io_responder.sv
module tb_cpu_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b1;
    logic [31:0] mem_a = 32'h0003_FFF0;
    logic [7:0]  mem_dout = 8'h00;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        program_done;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] stat_rd_cnt, stat_wr_cnt;
`endif

    cpu_mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in_n       (rst_in_n),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .program_done   (program_done)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_ram [int];
    logic [7:0]  m_tx [$];
    logic [7:0]  m_rx [$];
    logic [31:0] m_cnt = 0;
    logic [31:0] m_snap = 0;
    logic [7:0]  m_din = 0;
    bit          m_din_ok = 1;
    bit          m_done = 0;

    always @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            m_tx.delete();
            m_rx.delete();
            m_cnt = 0; m_snap = 0; m_din = 0; m_din_ok = 1; m_done = 0;
        end else begin
            logic [17:0] a;
            bit          io, tx_req, tx_pop;
            logic [7:0]  tx_byte;
            int          txn, rxn;
            a       = mem_a[17:0];
            io      = (a[17:16] == 2'b11);
            tx_req  = 0;
            tx_byte = mem_dout;
            txn     = m_tx.size();
            rxn     = m_rx.size();
            tx_pop  = (txn > 0) && tx_ready;
            if (mem_wr) begin
                if (!io) m_ram[int'(a[16:0])] = mem_dout;
                else if (a == 18'h30000) tx_req = (mem_dout != 0);
                else if (a == 18'h30004) begin
                    if (!m_done) begin tx_req = 1; tx_byte = 8'h00; end
                    m_done = 1;
                end
            end else begin
                m_din_ok = 1;
                if (!io) begin
                    if (m_ram.exists(int'(a[16:0]))) m_din = m_ram[int'(a[16:0])];
                    else m_din_ok = 0;
                end else if (a == 18'h30000) begin
                    if (rxn > 0) m_din = m_rx.pop_front();
                    else m_din = 8'h00;
                end else if (a >= 18'h30004 && a <= 18'h30007) begin
                    if (a[1:0] == 2'd0) m_snap = m_cnt;
                    m_din = 8'(m_snap >> (8 * a[1:0]));
                end else begin
                    m_din = 8'h00;
                end
            end
            if (rx_valid && rxn != 16) m_rx.push_back(rx_data);
            if (tx_pop) void'(m_tx.pop_front());
            if (tx_req && (txn < 16 || tx_pop)) m_tx.push_back(tx_byte);
            m_cnt = m_cnt + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_in) begin
        if (m_din_ok) chk("mem_din", {24'd0, mem_din}, {24'd0, m_din});
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx.size() > 0});
        if (m_tx.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, m_tx[0]});
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_rx.size() != 16});
        chk("io_buffer_full", {31'd0, io_buffer_full}, {31'd0, m_tx.size() >= 14});
        chk("program_done", {31'd0, program_done}, {31'd0, m_done});
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a = a; mem_wr = wr; mem_dout = d;
        @(negedge clk_in);
    endtask

    task automatic idle();
        step(32'h0003_FFF0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] b0, b1, b2, b3;
        #1 rst_in_n = 1'b0;
        #2;
        chk("rst_mem_din", {24'd0, mem_din}, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'h1);
        chk("rst_ibf", {31'd0, io_buffer_full}, 32'h0);
        chk("rst_done", {31'd0, program_done}, 32'h0);
        @(negedge clk_in);
        rst_in_n = 1'b1;

        // RAM: read-after-write, aliasing, ignored upper address bits
        step(32'h0000_0010, 1'b1, 8'hA5);
        step(32'h0000_0010, 1'b0, 8'h00);
        chk("ram_raw", {24'd0, mem_din}, 32'hA5);
        step(32'h0001_FFFF, 1'b1, 8'h3C);
        step(32'h0002_0010, 1'b0, 8'h00);
        chk("ram_alias_rd", {24'd0, mem_din}, 32'hA5);
        step(32'h0001_FFFF, 1'b0, 8'h00);
        chk("ram_top", {24'd0, mem_din}, 32'h3C);
        step(32'hFFFC_0010, 1'b0, 8'h00);
        chk("ram_hi_bits", {24'd0, mem_din}, 32'hA5);
        step(32'h0002_0020, 1'b1, 8'h77);
        step(32'h0000_0020, 1'b0, 8'h00);
        chk("ram_alias_wr", {24'd0, mem_din}, 32'h77);

        // RX FIFO
        rx_valid = 1'b1; rx_data = 8'h41; idle();
        rx_data = 8'h42; idle();
        rx_valid = 1'b0;
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_pop1", {24'd0, mem_din}, 32'h41);
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_pop2", {24'd0, mem_din}, 32'h42);
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_empty", {24'd0, mem_din}, 32'h00);
        chk("rx_ready_empty", {31'd0, rx_ready}, 32'h1);

        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'(8'h80 + i);
            idle();
        end
        rx_valid = 1'b0;
        chk("rx_full", {31'd0, rx_ready}, 32'h0);
        step(32'h0003_0000, 1'b0, 8'h00);
        chk("rx_full_head", {24'd0, mem_din}, 32'h80);
        for (int i = 0; i < 16; i++) step(32'h0003_0000, 1'b0, 8'h00);

        // TX FIFO fill with back-pressure
        tx_ready = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step(32'h0003_0000, 1'b1, 8'(i));
            if (i == 13) chk("ibf_at13", {31'd0, io_buffer_full}, 32'h0);
        end
        chk("ibf_at14", {31'd0, io_buffer_full}, 32'h1);
        step(32'h0003_0000, 1'b1, 8'h0F);
        step(32'h0003_0000, 1'b1, 8'h10);
        step(32'h0003_0000, 1'b1, 8'h11);   // dropped: FIFO full
        step(32'h0003_0000, 1'b1, 8'h00);   // zero byte ignored
        chk("tx_head_full", {24'd0, tx_data}, 32'h01);
        // push into a full FIFO succeeds when a pop happens the same cycle
        tx_ready = 1'b1;
        step(32'h0003_0000, 1'b1, 8'h55);
        chk("tx_head_after_pop", {24'd0, tx_data}, 32'h02);
        chk("ibf_still_full", {31'd0, io_buffer_full}, 32'h1);
        repeat (17) idle();
        chk("tx_drained", {31'd0, tx_valid}, 32'h0);

        // program stop
        step(32'h0003_0004, 1'b1, 8'h99);
        chk("done_set", {31'd0, program_done}, 32'h1);
        chk("done_push_v", {31'd0, tx_valid}, 32'h1);
        chk("done_push_d", {24'd0, tx_data}, 32'h00);
        idle();
        chk("done_pulse_end", {31'd0, tx_valid}, 32'h0);
        step(32'h0003_0004, 1'b1, 8'h00);
        chk("done_no_repush", {31'd0, tx_valid}, 32'h0);
        chk("done_sticky", {31'd0, program_done}, 32'h1);

        // asynchronous reset with TX holding 5 bytes and read data pending
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) step(32'h0003_0000, 1'b1, 8'(8'hB0 + i));
        step(32'h0000_0010, 1'b0, 8'h00);
        chk("pre_rst_din", {24'd0, mem_din}, 32'hA5);
        #2 rst_in_n = 1'b0;
        mem_a = 32'h0003_FFF0; mem_wr = 1'b0;
        #1;
        chk("arst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("arst_ibf", {31'd0, io_buffer_full}, 32'h0);
        chk("arst_done", {31'd0, program_done}, 32'h0);
        chk("arst_din", {24'd0, mem_din}, 32'h0);
        @(negedge clk_in);
        rst_in_n = 1'b1;

        // cycle counter snapshot: 1000 edges after reset release
        repeat (1000) idle();
        step(32'h0003_0004, 1'b0, 8'h00); b0 = mem_din;
        step(32'h0003_0005, 1'b0, 8'h00); b1 = mem_din;
        step(32'h0003_0006, 1'b0, 8'h00); b2 = mem_din;
        step(32'h0003_0007, 1'b0, 8'h00); b3 = mem_din;
        chk("cnt_b1", {24'd0, b1}, 32'h03);
        chk("cnt_word", {b3, b2, b1, b0}, 32'd1000);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_mem_io_responder.md
Name: cpu_mem_io_responder

Overview:
- Target-side responder for the CPU byte-wide memory bus (mem_a, mem_dout, mem_wr out of the CPU; mem_din, io_buffer_full back into it).
- Contains a 128 KB byte RAM, an RX byte FIFO, a TX byte FIFO, a cycle counter and a program-stop flag.
- Sits between the CPU top and the UART/host wrapper.
- Returns read data exactly one cycle after the request; writes complete in the request cycle.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB)
TX_DEPTH_LOG2, 4, TX FIFO depth = 16 entries
RX_DEPTH_LOG2, 4, RX FIFO depth = 16 entries

Ports:
clk_in  in  1  system clock
rst_in_n  in  1  asynchronous active-low reset
mem_a  in  32  CPU address; only [17:0] decoded
mem_dout  in  8  CPU write data
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data returned to CPU
io_buffer_full  out  1  TX FIFO near-full back-pressure to CPU
tx_data  out  8  TX FIFO head byte to UART
tx_valid  out  1  TX FIFO non-empty
tx_ready  in  1  UART consumes head byte when tx_valid & tx_ready
rx_data  in  8  byte from UART receiver
rx_valid  in  1  push rx_data when rx_valid & rx_ready
rx_ready  out  1  RX FIFO not full
program_done  out  1  sticky; set by a write to 0x30004

Behaviour:
- Reset: rst_in_n=0 asynchronously clears mem_din=0, both FIFOs empty (tx_valid=0, rx_ready=1, io_buffer_full=0), program_done=0, cycle counter=0, snapshot=0. RAM contents are not cleared.
- Decode: io = (mem_a[17:16]==2'b11); RAM index = mem_a[16:0]. Accesses with mem_a[17:16]==2'b10 alias RAM.
- Every cycle is a request. A read is implied whenever mem_wr=0; no valid strobe.
- RAM write (mem_wr=1, !io): ram[idx] <= mem_dout at the clock edge.
- RAM read: mem_din <= ram[idx] registered, visible the following cycle.
- Read-after-write to the same address in consecutive cycles returns the new byte.
- IO read 0x30000: pops RX FIFO. mem_din <= head byte next cycle, or 0x00 if empty (no pop).
- IO read 0x30004-0x30007: returns cycle-counter bytes, little-endian by mem_a[1:0].
  - A read at offset 0 loads snapshot <= counter and returns counter[7:0] in the same path.
  - Offsets 1-3 return snapshot bytes 1-3, so a 4-byte LW is coherent.
- Other IO reads return 0x00.
- IO write 0x30000:
  - Nonzero byte is pushed to the TX FIFO.
  - 0x00 is ignored.
  - A push into a full FIFO is dropped.
- IO write 0x30004: sets program_done and pushes 0x00 into the TX FIFO once (dropped if full). Repeated writes do not push again.
- Other IO writes are ignored.
- Cycle counter: 32-bit, increments every cycle after reset, wraps 0xFFFFFFFF -> 0.
- io_buffer_full = (tx_count >= TX_DEPTH-2). It is a registered count compare, giving margin for a CPU write already in flight.
- FIFOs: circular, pointers wrap modulo depth, separate count register.
  - Simultaneous push and pop on a full or empty FIFO: the pop is honoured only if count>0; the push only if count<DEPTH or a pop occurs in the same cycle.
  - Count is unchanged when both succeed.
- tx_data/tx_valid reflect the FIFO head combinationally from registers. rx_ready = (rx_count != RX_DEPTH).
- Reset mid-operation: pending read data is discarded, FIFOs are flushed, program_done is cleared.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined: adds output ports stat_rd_cnt[31:0] and stat_wr_cnt[31:0].
  - Counters count RAM reads and RAM writes; IO accesses are excluded.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 next cycle -> mem_din=0xA5 one cycle after the read request.
- Push rx bytes 0x41,0x42; read 0x30000 twice -> mem_din 0x41 then 0x42. A third read returns 0x00 with rx_ready=1.
- With tx_ready=0, write 0x01..0x0E to 0x30000 -> io_buffer_full rises when count reaches 14. Writes 15-16 are accepted; a 17th write is dropped (count stays 16). Write 0x00 -> count unchanged.
- After 1000 cycles from reset, read 0x30004..0x30007 -> the 4 bytes reassemble to the snapshot value. Bytes 1-3 are unchanged by the counter advancing during the access.
- Write 0x30004 with tx_ready=1 -> program_done=1 and tx_valid pulses with tx_data=0x00 once. A second write to 0x30004 produces no further push.
- Assert rst_in_n=0 mid-stream with TX holding 5 bytes -> tx_valid=0, io_buffer_full=0, program_done=0, mem_din=0 immediately (asynchronous).
